// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and format/occupancy encodings for the pipelined immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6,
    FMT_SYS  = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decode with sign extension to XLEN.
// Optional macro IMM_GEN_CSR_ZIMM_EN: CSR*I words return their zero-extended zimm field.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit U_PRESHIFT = 1'b1
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic signed [31:0] imm32_s;

  // Build a 32-bit signed immediate per opcode; widening to XLEN happens below.
  always_comb begin
    imm32_s   = 32'sd0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt_o   = FMT_I;
        imm32_s = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_o = FMT_U;
        if (U_PRESHIFT) begin
          imm32_s = {inst_i[31:12], 12'h000};
        end else begin
          imm32_s = {{12{inst_i[31]}}, inst_i[31:12]};
        end
      end
      OP_STORE: begin
        fmt_o   = FMT_S;
        imm32_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OP_BRANCH: begin
        fmt_o   = FMT_B;
        imm32_s = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OP_JAL: begin
        fmt_o   = FMT_J;
        imm32_s = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OP_R: begin
        fmt_o = FMT_R;
      end
      OP_SYSTEM: begin
        fmt_o = FMT_SYS;
`ifdef IMM_GEN_CSR_ZIMM_EN
        // funct3[2] selects the immediate CSR forms; zimm top bit is 0 so sext == zext
        if (inst_i[14]) begin
          imm32_s = {27'd0, inst_i[19:15]};
        end else begin
          imm32_s = 32'sd0;
        end
`endif
      end
      default: begin
        fmt_o     = FMT_NONE;
        illegal_o = 1'b1;
      end
    endcase
  end

  assign imm_o = XLEN'(imm32_s);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on push, results queued in a DEPTH-entry FIFO.
// Optional macro IMM_GEN_CSR_ZIMM_EN (see imm_decode) enables CSR zimm extraction.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter bit U_PRESHIFT = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_valid_i,
  output logic                     inst_ready_o,
  input  logic [31:0]              instruction_bus_i,
  output logic                     imm_valid_o,
  input  logic                     imm_ready_i,
  output logic [XLEN-1:0]          immediate_o,
  output fmt_e                     fmt_o,
  output logic                     illegal_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  entry_t dec_s;
  entry_t head_s;
  occ_e   occ_s;
  logic   push_s;
  logic   pop_s;

  imm_decode #(
    .XLEN       (XLEN),
    .U_PRESHIFT (U_PRESHIFT)
  ) u_decode (
    .inst_i    (instruction_bus_i),
    .imm_o     (dec_s.imm),
    .fmt_o     (dec_s.fmt),
    .illegal_o (dec_s.illegal)
  );

  // Occupancy classification from the registered count only.
  always_comb begin
    if (count_q == CW'(0)) begin
      occ_s = OCC_EMPTY;
    end else if (count_q == CW'(DEPTH)) begin
      occ_s = OCC_FULL;
    end else begin
      occ_s = OCC_PARTIAL;
    end
  end

  assign inst_ready_o = (occ_s != OCC_FULL);
  assign imm_valid_o  = (occ_s != OCC_EMPTY);
  assign push_s       = inst_valid_i & inst_ready_o;
  assign pop_s        = imm_valid_o & imm_ready_i;

  // Next-state for storage, pointers and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = dec_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every queued entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry is driven straight from storage; idle outputs read as zero/FMT_NONE.
  always_comb begin
    if (imm_valid_o) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
    end
  end

  assign immediate_o = head_s.imm;
  assign fmt_o       = head_s.fmt;
  assign illegal_o   = head_s.illegal;
  assign count_o     = count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a default instance (XLEN=32, preshifted U) and an
// XLEN=64 legacy-U instance share the same stimulus.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk;
  logic        reset;
  logic        inst_valid_i;
  logic [31:0] instruction_bus_i;
  logic        imm_ready_i;

  logic        ready32, valid32, ill32;
  logic [31:0] imm32;
  fmt_e        fmt32;
  logic [1:0]  cnt32;

  logic        ready64, valid64, ill64;
  logic [63:0] imm64;
  fmt_e        fmt64;
  logic [1:0]  cnt64;

  int n_vec = 0;
  int n_err = 0;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .U_PRESHIFT(1'b1)) dut (
    .clk (clk), .reset (reset),
    .inst_valid_i (inst_valid_i), .inst_ready_o (ready32),
    .instruction_bus_i (instruction_bus_i),
    .imm_valid_o (valid32), .imm_ready_i (imm_ready_i),
    .immediate_o (imm32), .fmt_o (fmt32), .illegal_o (ill32), .count_o (cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .U_PRESHIFT(1'b0)) dut64 (
    .clk (clk), .reset (reset),
    .inst_valid_i (inst_valid_i), .inst_ready_o (ready64),
    .instruction_bus_i (instruction_bus_i),
    .imm_valid_o (valid64), .imm_ready_i (imm_ready_i),
    .immediate_o (imm64), .fmt_o (fmt64), .illegal_o (ill64), .count_o (cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                            input fmt_e ef, input logic eill);
    check({tag, ".valid"}, 64'(valid32), 64'd1);
    check({tag, ".imm32"}, 64'(imm32), 64'(e32));
    check({tag, ".fmt32"}, 64'(fmt32), 64'(ef));
    check({tag, ".ill32"}, 64'(ill32), 64'(eill));
    check({tag, ".imm64"}, imm64, e64);
    check({tag, ".fmt64"}, 64'(fmt64), 64'(ef));
    check({tag, ".ill64"}, 64'(ill64), 64'(eill));
  endtask

  // Single word, consumer always ready: result visible one cycle after the push edge.
  task automatic single(input string tag, input logic [31:0] w, input logic [31:0] e32,
                        input logic [63:0] e64, input fmt_e ef, input logic eill);
    @(negedge clk);
    imm_ready_i       = 1'b1;
    inst_valid_i      = 1'b1;
    instruction_bus_i = w;
    @(negedge clk);
    inst_valid_i = 1'b0;
    check({tag, ".count"}, 64'(cnt32), 64'd1);
    check_head(tag, e32, e64, ef, eill);
    @(negedge clk);
    check({tag, ".drained"}, 64'(cnt32), 64'd0);
  endtask

  logic [31:0] bw   [3];
  logic [31:0] be32 [3];
  logic [63:0] be64 [3];
  fmt_e        bf   [3];
  logic [31:0] zimm_exp;

  initial begin
    reset             = 1'b0;
    inst_valid_i      = 1'b0;
    instruction_bus_i = 32'h0000_0000;
    imm_ready_i       = 1'b0;

    #12;
    check("rst.count", 64'(cnt32), 64'd0);
    check("rst.valid", 64'(valid32), 64'd0);
    check("rst.imm", 64'(imm32), 64'd0);
    check("rst.fmt", 64'(fmt32), 64'(FMT_NONE));
    check("rst.ill", 64'(ill32), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst.ready", 64'(ready32), 64'd1);

    single("addi", 32'hFFF0_0093, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
    single("lui",  32'h1234_50B7, 32'h1234_5000, 64'h0000_0000_0001_2345, FMT_U, 1'b0);
    single("luineg", 32'h8000_00B7, 32'h8000_0000, 64'hFFFF_FFFF_FFF8_0000, FMT_U, 1'b0);
    single("auipc", 32'hFFFF_F017, 32'hFFFF_F000, 64'hFFFF_FFFF_FFFF_FFFF, FMT_U, 1'b0);
    single("lw",   32'h8000_2003, 32'hFFFF_F800, 64'hFFFF_FFFF_FFFF_F800, FMT_I, 1'b0);
    single("jalr", 32'h7FF0_0067, 32'h0000_07FF, 64'h0000_0000_0000_07FF, FMT_I, 1'b0);
    single("rtype", 32'h00B5_0533, 32'h0, 64'h0, FMT_R, 1'b0);
    single("unk",  32'h0000_007F, 32'h0, 64'h0, FMT_NONE, 1'b1);
    single("csrrw", 32'h3401_1073, 32'h0, 64'h0, FMT_SYS, 1'b0);
`ifdef IMM_GEN_CSR_ZIMM_EN
    zimm_exp = 32'h0000_000F;
`else
    zimm_exp = 32'h0000_0000;
`endif
    single("csrrwi", 32'h0007_D073, zimm_exp, 64'(zimm_exp), FMT_SYS, 1'b0);

    // Back-to-back stream with ready held: simultaneous push/pop keeps count at 1.
    bw[0] = 32'hFE11_2E23; be32[0] = 32'hFFFF_FFFC; be64[0] = 64'hFFFF_FFFF_FFFF_FFFC; bf[0] = FMT_S;
    bw[1] = 32'hFE00_0CE3; be32[1] = 32'hFFFF_FFF8; be64[1] = 64'hFFFF_FFFF_FFFF_FFF8; bf[1] = FMT_B;
    bw[2] = 32'h0080_00EF; be32[2] = 32'h0000_0008; be64[2] = 64'h0000_0000_0000_0008; bf[2] = FMT_J;
    @(negedge clk);
    imm_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_valid_i      = 1'b1;
      instruction_bus_i = bw[i];
      @(negedge clk);
      check($sformatf("b2b%0d.count", i), 64'(cnt32), 64'd1);
      check_head($sformatf("b2b%0d", i), be32[i], be64[i], bf[i], 1'b0);
    end
    inst_valid_i = 1'b0;
    @(negedge clk);
    check("b2b.drained", 64'(cnt32), 64'd0);

    // Fill to DEPTH with consumer stalled, try one extra word, then drain.
    imm_ready_i       = 1'b0;
    inst_valid_i      = 1'b1;
    instruction_bus_i = 32'hFFF0_0093;
    @(negedge clk);
    instruction_bus_i = 32'h0050_0093;
    @(negedge clk);
    check("full.count", 64'(cnt32), 64'd2);
    check("full.ready", 64'(ready32), 64'd0);
    check("full.ready64", 64'(ready64), 64'd0);
    instruction_bus_i = 32'h0080_00EF;
    @(negedge clk);
    inst_valid_i = 1'b0;
    check("full.ignored", 64'(cnt32), 64'd2);
    check_head("full.hold", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
    imm_ready_i = 1'b1;
    @(negedge clk);
    check("drain1.count", 64'(cnt32), 64'd1);
    check("drain1.ready", 64'(ready32), 64'd1);
    check_head("drain1", 32'h0000_0005, 64'h5, FMT_I, 1'b0);
    @(negedge clk);
    check("drain2.count", 64'(cnt32), 64'd0);
    check("drain2.valid", 64'(valid32), 64'd0);
    check("drain2.imm", 64'(imm32), 64'd0);

    // Asynchronous reset in mid-cycle with two entries queued.
    imm_ready_i       = 1'b0;
    inst_valid_i      = 1'b1;
    instruction_bus_i = 32'hFE11_2E23;
    @(negedge clk);
    @(negedge clk);
    inst_valid_i = 1'b0;
    check("pre_rst.count", 64'(cnt32), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    check("arst.valid", 64'(valid32), 64'd0);
    check("arst.count", 64'(cnt32), 64'd0);
    check("arst.count64", 64'(cnt64), 64'd0);
    check("arst.ready", 64'(ready32), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    single("post_rst", 32'hFFF0_0093, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
